// File: rtl/sha256_msg_padder.sv
// Collects UART bytes until the line goes idle, then streams one SHA-256 padded
// 512-bit block as 16 big-endian words over a valid/ready handshake.
//
// state   | meaning
// IDLE    | waiting for the first byte of a message
// COLLECT | storing bytes, idle timer running between bytes
// ERROR   | message too long, swallowing bytes until the line goes idle
// SEND    | streaming the padded block word by word
module sha256_msg_padder #(
    parameter int CLKS_PER_BIT = 868,
    parameter int IDLE_BITS    = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] w_data,
    output logic [3:0]  w_idx,
    output logic        w_valid,
    input  logic        w_ready,
    output logic        w_last,
    output logic        busy,
    output logic        ovf_err,
    output logic        drop_err
);
    localparam int IDLE_CLKS = CLKS_PER_BIT * IDLE_BITS;
    localparam int TW        = $clog2(IDLE_CLKS + 1);
    localparam int MAX_BYTES = 55;
    localparam logic [TW-1:0] TIMEOUT = TW'(IDLE_CLKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_ERROR, S_SEND} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [5:0]      r_cnt;
    logic [TW-1:0]   r_timer;
    logic [7:0]      r_buf [56];
    logic [3:0]      r_idx;
    logic            r_valid;
    logic            r_ovf;
    logic            r_drop;
    logic            w_timeout;
    logic            w_accept;
    logic [31:0]     w_word;
    logic [5:0]      w_pos;
    logic [7:0]      w_byte;

    // A byte on the timeout cycle wins: the message keeps growing.
    assign w_timeout = (r_timer == TIMEOUT) && !rx_valid;
    assign w_accept  = r_valid && w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (rx_valid) w_state_nxt = S_COLLECT;
            S_COLLECT: begin
                if (rx_valid && (r_cnt == 6'(MAX_BYTES))) w_state_nxt = S_ERROR;
                else if (w_timeout)                       w_state_nxt = S_SEND;
            end
            S_ERROR:   if (w_timeout) w_state_nxt = S_IDLE;
            S_SEND:    if (w_accept && (r_idx == 4'd15)) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_timer <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_drop  <= 1'b0;
            for (int i = 0; i < 56; i++) r_buf[i] <= '0;
        end else begin
            r_ovf  <= 1'b0;
            r_drop <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (rx_valid) begin
                        r_buf[0] <= rx_data;
                        r_cnt    <= 6'd1;
                    end
                end
                S_COLLECT: begin
                    if (rx_valid) begin
                        r_timer <= '0;
                        if (r_cnt != 6'(MAX_BYTES)) begin
                            r_buf[r_cnt] <= rx_data;
                            r_cnt        <= r_cnt + 6'd1;
                        end
                    end else if (w_timeout) begin
                        r_timer <= '0;
                        r_idx   <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_ERROR: begin
                    if (rx_valid) begin
                        r_timer <= '0;
                    end else if (w_timeout) begin
                        r_timer <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_SEND: begin
                    r_drop <= rx_valid;
                    if (w_accept) r_idx <= r_idx + 4'd1;
                    if (w_accept && (r_idx == 4'd15)) begin
                        r_valid <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_valid <= 1'b1;
                    end
                end
                default: r_timer <= '0;
            endcase
        end
    end

    // Padding is generated on the fly from the byte count; stale buffer bytes
    // beyond the count are never visible.
    always_comb begin
        w_word = '0;
        w_pos  = '0;
        w_byte = '0;
        if (r_idx == 4'd15) begin
            w_word = {23'b0, r_cnt, 3'b0};
        end else if (r_idx != 4'd14) begin
            for (int k = 0; k < 4; k++) begin
                w_pos = {r_idx, 2'b00} + 6'(k);
                if (w_pos < r_cnt)       w_byte = r_buf[w_pos];
                else if (w_pos == r_cnt) w_byte = 8'h80;
                else                     w_byte = 8'h00;
                w_word[31-8*k -: 8] = w_byte;
            end
        end
    end

    assign w_data   = r_valid ? w_word : 32'h0;
    assign w_idx    = r_idx;
    assign w_valid  = r_valid;
    assign w_last   = r_valid && (r_idx == 4'd15);
    assign busy     = (r_state != S_IDLE);
    assign ovf_err  = r_ovf;
    assign drop_err = r_drop;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed and randomized bench for the SHA-256 message padder, checked against
// a byte-array model of standard SHA-256 single-block padding.
module tb_sha256_msg_padder;
    localparam int CPB       = 4;
    localparam int IB        = 20;
    localparam int IDLE_CLKS = CPB * IB;
    localparam int UART_GAP  = 10 * CPB - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        w_ready = 1'b0;
    logic [31:0] w_data;
    logic [3:0]  w_idx;
    logic        w_valid;
    logic        w_last;
    logic        busy;
    logic        ovf_err;
    logic        drop_err;

    sha256_msg_padder #(.CLKS_PER_BIT(CPB), .IDLE_BITS(IB)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .w_data(w_data), .w_idx(w_idx), .w_valid(w_valid), .w_ready(w_ready),
        .w_last(w_last), .busy(busy), .ovf_err(ovf_err), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  msg [$];
    logic [31:0] exp_w [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Standard padding: message, 0x80, zeros, 64-bit big-endian bit length.
    function automatic void build_expected();
        logic [7:0]  blk [64];
        logic [63:0] bits;
        int          len;
        len  = msg.size();
        bits = 64'(len) * 64'd8;
        for (int i = 0; i < 64; i++) blk[i] = (i < len) ? msg[i] : ((i == len) ? 8'h80 : 8'h00);
        for (int i = 0; i < 8; i++) blk[56+i] = bits[63-8*i -: 8];
        for (int w = 0; w < 16; w++) exp_w[w] = {blk[4*w], blk[4*w+1], blk[4*w+2], blk[4*w+3]};
    endfunction

    task automatic set_abc();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
    endtask

    // gap < 0 picks a random inter-byte gap that never reaches the timeout.
    task automatic send_msg(input int gap);
        for (int i = 0; i < msg.size(); i++) begin
            rx_data  = msg[i];
            rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
            if (i != msg.size() - 1)
                repeat ((gap < 0) ? $urandom_range(1, IDLE_CLKS - 1) : gap) tick();
        end
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        int ovf = 0;
        while (!w_valid && k < 3 * IDLE_CLKS) begin
            tick();
            k++;
            if (ovf_err) ovf++;
        end
        chk({tag, "_first_valid"}, w_valid, 1);
        chk({tag, "_latency"}, k, IDLE_CLKS + 1);
        chk({tag, "_no_ovf"}, ovf, 0);
        chk({tag, "_busy"}, busy, 1);
    endtask

    // mode 0: ready always high, 1: toggling, 2: random.
    task automatic recv_block(input string tag, input int mode, input int drop_at);
        int          n = 0;
        int          cyc = 0;
        int          drops = 0;
        bit          sent = 0;
        bit          held = 0;
        logic [31:0] hd = '0;
        logic [3:0]  hi = '0;
        while (n < 16 && cyc < 300) begin
            case (mode)
                0:       w_ready = 1'b1;
                1:       w_ready = (cyc % 2 == 0);
                default: w_ready = 1'($urandom_range(0, 1));
            endcase
            if (drop_at >= 0 && n == drop_at && !sent) begin
                rx_data  = 8'h7A;
                rx_valid = 1'b1;
                sent     = 1;
            end
            chk($sformatf("%s_valid_c%0d", tag, cyc), w_valid, 1);
            if (held) begin
                chk($sformatf("%s_hold_data%0d", tag, n), w_data, hd);
                chk($sformatf("%s_hold_idx%0d", tag, n), w_idx, hi);
            end
            if (w_ready) begin
                chk($sformatf("%s_word%0d", tag, n), w_data, exp_w[n]);
                chk($sformatf("%s_idx%0d", tag, n), w_idx, n);
                chk($sformatf("%s_last%0d", tag, n), w_last, (n == 15));
                n++;
                held = 0;
            end else begin
                held = 1;
                hd   = w_data;
                hi   = w_idx;
            end
            tick();
            rx_valid = 1'b0;
            cyc++;
            if (drop_err) drops++;
        end
        w_ready = 1'b0;
        chk({tag, "_words"}, n, 16);
        chk({tag, "_valid_after"}, w_valid, 0);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_drops"}, drops, (drop_at >= 0) ? 1 : 0);
    endtask

    task automatic run_msg(input string tag, input int gap, input int mode, input int drop_at);
        build_expected();
        send_msg(gap);
        wait_valid(tag);
        recv_block(tag, mode, drop_at);
        repeat (3) tick();
    endtask

    initial begin
        int k;
        int ovf_cnt;
        int ovf_at;
        bit seen_valid;

        #12;
        chk("rst_w_valid", w_valid, 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_w_idx", w_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {w_last, ovf_err, drop_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        set_abc();
        run_msg("abc", UART_GAP, 0, -1);

        msg.delete();
        repeat (55) msg.push_back(8'h41);
        run_msg("len55", UART_GAP, 0, -1);

        msg.delete();
        repeat (56) msg.push_back(8'h42);
        send_msg(UART_GAP);
        chk("ovf_busy", busy, 1);
        k = 0; ovf_cnt = 0; ovf_at = -1; seen_valid = 0;
        while (k < IDLE_CLKS + 10) begin
            tick();
            k++;
            if (w_valid) seen_valid = 1;
            if (ovf_err) begin
                ovf_cnt++;
                ovf_at = k;
            end
        end
        chk("ovf_pulses", ovf_cnt, 1);
        chk("ovf_time", ovf_at, IDLE_CLKS);
        chk("ovf_no_block", seen_valid, 0);
        chk("ovf_idle", busy, 0);
        set_abc();
        run_msg("after_ovf", UART_GAP, 0, -1);

        set_abc();
        run_msg("toggle", UART_GAP, 1, -1);

        set_abc();
        run_msg("drop", UART_GAP, 0, 4);
        msg.delete();
        msg.push_back(8'h78);
        msg.push_back(8'h79);
        run_msg("after_drop", UART_GAP, 0, -1);

        set_abc();
        build_expected();
        send_msg(UART_GAP);
        wait_valid("pre_rst");
        w_ready = 1'b1;
        k = 0;
        while (w_idx != 4'd7 && k < 40) begin
            tick();
            k++;
        end
        chk("pre_rst_idx", w_idx, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_w_valid", w_valid, 0);
        chk("arst_w_idx", w_idx, 0);
        chk("arst_w_data", w_data, 0);
        chk("arst_busy_last", {busy, w_last}, 0);
        w_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        set_abc();
        run_msg("after_rst", UART_GAP, 0, -1);

        set_abc();
        run_msg("gap_edge", IDLE_CLKS - 1, 0, -1);

        for (int m = 0; m < 6; m++) begin
            msg.delete();
            repeat ($urandom_range(1, 55)) msg.push_back(8'($urandom));
            run_msg($sformatf("rand%0d", m), -1, 2, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
